// File: rtl/alu_wide_sequencer.sv
// Multi-precision sequencer around a 16-bit combinational ALU: accepts one wide
// operation, issues it LSW first with carry chaining, and holds the wide result until accepted.
module alu_wide_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] op_a,
  input  logic [16*WORDS-1:0] op_b,
  input  logic [3:0]          op_select,
  input  logic                op_mode,
  input  logic                op_carry_in,
  output logic [15:0]         alu_in_a,
  output logic [15:0]         alu_in_b,
  output logic [3:0]          alu_select,
  output logic                alu_mode,
  output logic                alu_carry_in,
  input  logic [15:0]         alu_out,
  input  logic                alu_carry_out,
  input  logic                alu_compare,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] result,
  output logic                carry_out,
  output logic                equal,
  output logic                zero
);

  localparam int W     = 16 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     a_reg, b_reg, result_reg;
  logic [3:0]       select_reg;
  logic             mode_reg;
  logic             carry_reg;
  logic             eq_reg;
  logic             zero_reg;
  logic [IDX_W-1:0] idx_reg;

  logic [15:0]      a_words [WORDS];
  logic [15:0]      b_words [WORDS];
  logic [W-1:0]     result_merged;
  logic             accept;
  logic             run_last;

  // Word views of the latched operands, and the result with the current ALU word merged in.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
    assign a_words[gi] = a_reg[gi*16 +: 16];
    assign b_words[gi] = b_reg[gi*16 +: 16];
    assign result_merged[gi*16 +: 16] =
      (idx_reg == IDX_W'(gi)) ? alu_out : result_reg[gi*16 +: 16];
  end

  assign in_ready = rst_n && (state_reg == IDLE);
  assign accept   = in_valid && in_ready;
  assign run_last = (idx_reg == LAST_IDX);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (run_last)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      select_reg <= '0;
      mode_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      eq_reg     <= 1'b0;
      zero_reg   <= 1'b0;
      result_reg <= '0;
      idx_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg      <= op_a;
            b_reg      <= op_b;
            select_reg <= op_select;
            mode_reg   <= op_mode;
            carry_reg  <= op_carry_in;
            eq_reg     <= 1'b1;
            result_reg <= '0;
            idx_reg    <= '0;
          end
        end
        RUN: begin
          result_reg <= result_merged;
          // The ALU already reports borrow for subtract selects, so chain it unmodified.
          carry_reg  <= alu_carry_out;
          eq_reg     <= eq_reg & alu_compare;
          if (run_last) zero_reg <= (result_merged == '0);
          else          idx_reg  <= idx_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_in_a     = (state_reg == RUN) ? a_words[idx_reg] : a_words[0];
  assign alu_in_b     = (state_reg == RUN) ? b_words[idx_reg] : b_words[0];
  assign alu_select   = select_reg;
  assign alu_mode     = mode_reg;
  assign alu_carry_in = carry_reg;

  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign carry_out = carry_reg;
  assign equal     = eq_reg;
  assign zero      = zero_reg;

endmodule
